// File: rtl/pipe_pkg.sv
// Shared types and helpers for the configurable pipeline stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // addi x0, x0, 0: the canonical RISC-V no-op presented while a stage is empty.
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
    logic [31:0] result;
    if (value >= max_value) begin
      result = max_value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; sticks at all-ones and clears only on reset.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [31:0] MAX_VAL = 32'((64'd1 << CNT_W) - 64'd1);

  logic [CNT_W-1:0] count_r;

  // Count one event per cycle, holding at the maximum value.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_r <= '0;
    end else if (inc_i) begin
      count_r <= CNT_W'(sat_inc(32'(count_r), MAX_VAL));
    end
  end

  assign count_o = count_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, stall, flush, NOP bubble,
// optional two-entry skid buffer and bubble/stall performance counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter int          PC_W      = 32,
  parameter int          SKID      = 0,
  parameter logic [31:0] NOP_VALUE = RV_NOP,
  parameter int          CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic [PC_W-1:0]  pc_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [PC_W-1:0]  pc_o,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [WIDTH-1:0] NOP_DATA = WIDTH'(NOP_VALUE);

  logic eff_ready_s;
  logic accept_s;
  logic issue_s;
  logic bubble_inc_s;
  logic stall_inc_s;

  assign eff_ready_s  = ready_i & ~stall_i;
  assign accept_s     = valid_i & ready_o;
  assign issue_s      = valid_o & eff_ready_s;
  assign bubble_inc_s = ~valid_o;
  assign stall_inc_s  = valid_o & ~eff_ready_s;

  if (SKID == 0) begin : g_single
    logic             valid_r;
    logic [WIDTH-1:0] data_r;
    logic [PC_W-1:0]  pc_r;

    // A flush always swallows the incoming payload, so the stage is ready then.
    assign ready_o = flush_i | ~valid_r | eff_ready_s;

    // Single holding register; empty slots carry the NOP so outputs stay registered.
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        valid_r <= 1'b0;
        data_r  <= NOP_DATA;
        pc_r    <= '0;
      end else if (flush_i) begin
        valid_r <= 1'b0;
        data_r  <= NOP_DATA;
        pc_r    <= '0;
      end else if (accept_s) begin
        valid_r <= 1'b1;
        data_r  <= data_i;
        pc_r    <= pc_i;
      end else if (issue_s) begin
        valid_r <= 1'b0;
        data_r  <= NOP_DATA;
        pc_r    <= '0;
      end
    end

    assign valid_o = valid_r;
    assign data_o  = data_r;
    assign pc_o    = pc_r;
  end else begin : g_skid
    state_t           state_r;
    logic             ready_r;
    logic             valid_r;
    logic [WIDTH-1:0] main_data_r;
    logic [PC_W-1:0]  main_pc_r;
    logic [WIDTH-1:0] skid_data_r;
    logic [PC_W-1:0]  skid_pc_r;

    assign ready_o = ready_r;

    // Occupancy FSM; ready is registered from the next state so it never
    // depends combinationally on downstream ready.
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        state_r     <= ST_EMPTY;
        ready_r     <= 1'b1;
        valid_r     <= 1'b0;
        main_data_r <= NOP_DATA;
        main_pc_r   <= '0;
        skid_data_r <= NOP_DATA;
        skid_pc_r   <= '0;
      end else if (flush_i) begin
        state_r     <= ST_EMPTY;
        ready_r     <= 1'b1;
        valid_r     <= 1'b0;
        main_data_r <= NOP_DATA;
        main_pc_r   <= '0;
        skid_data_r <= NOP_DATA;
        skid_pc_r   <= '0;
      end else begin
        case (state_r)
          ST_EMPTY: begin
            if (accept_s) begin
              state_r     <= ST_ONE;
              valid_r     <= 1'b1;
              main_data_r <= data_i;
              main_pc_r   <= pc_i;
            end
          end
          ST_ONE: begin
            if (accept_s && issue_s) begin
              main_data_r <= data_i;
              main_pc_r   <= pc_i;
            end else if (accept_s) begin
              state_r     <= ST_TWO;
              ready_r     <= 1'b0;
              skid_data_r <= data_i;
              skid_pc_r   <= pc_i;
            end else if (issue_s) begin
              state_r     <= ST_EMPTY;
              valid_r     <= 1'b0;
              main_data_r <= NOP_DATA;
              main_pc_r   <= '0;
            end
          end
          ST_TWO: begin
            if (issue_s) begin
              state_r     <= ST_ONE;
              ready_r     <= 1'b1;
              main_data_r <= skid_data_r;
              main_pc_r   <= skid_pc_r;
              skid_data_r <= NOP_DATA;
              skid_pc_r   <= '0;
            end
          end
          default: begin
            state_r     <= ST_EMPTY;
            ready_r     <= 1'b1;
            valid_r     <= 1'b0;
            main_data_r <= NOP_DATA;
            main_pc_r   <= '0;
          end
        endcase
      end
    end

    assign valid_o = valid_r;
    assign data_o  = main_data_r;
    assign pc_o    = main_pc_r;
  end

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (bubble_inc_s),
    .count_o(bubble_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (stall_inc_s),
    .count_o(stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: SKID=0, SKID=1 and a 4-bit-counter instance.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [31:0] data_i;
  logic [31:0] pc_i;
  logic        ready_i;
  logic        stall_i;
  logic        flush_i;

  logic        s0_ready, s0_valid;
  logic [31:0] s0_data, s0_pc;
  logic [15:0] s0_bub, s0_stl;
  logic        s1_ready, s1_valid;
  logic [31:0] s1_data, s1_pc;
  logic [15:0] s1_bub, s1_stl;
  logic        c4_ready, c4_valid;
  logic [31:0] c4_data, c4_pc;
  logic [3:0]  c4_bub, c4_stl;

  always #5 clk = ~clk;

  pipe_stage_reg #(.SKID(0)) u_s0 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(s0_ready), .data_i(data_i),
    .pc_i(pc_i), .valid_o(s0_valid), .ready_i(ready_i), .data_o(s0_data), .pc_o(s0_pc),
    .stall_i(stall_i), .flush_i(flush_i), .bubble_cnt_o(s0_bub), .stall_cnt_o(s0_stl)
  );

  pipe_stage_reg #(.SKID(1)) u_s1 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(s1_ready), .data_i(data_i),
    .pc_i(pc_i), .valid_o(s1_valid), .ready_i(ready_i), .data_o(s1_data), .pc_o(s1_pc),
    .stall_i(stall_i), .flush_i(flush_i), .bubble_cnt_o(s1_bub), .stall_cnt_o(s1_stl)
  );

  pipe_stage_reg #(.SKID(0), .CNT_W(4)) u_c4 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(c4_ready), .data_i(data_i),
    .pc_i(pc_i), .valid_o(c4_valid), .ready_i(ready_i), .data_o(c4_data), .pc_o(c4_pc),
    .stall_i(stall_i), .flush_i(flush_i), .bubble_cnt_o(c4_bub), .stall_cnt_o(c4_stl)
  );

  typedef struct {
    int          phase;
    int          sel;
    logic        v;
    logic [31:0] d;
    logic        rdy;
    logic        stl;
    logic        fl;
    logic        ev;
    logic [31:0] ed;
    logic        er;
    int          eb;
    int          es;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   fails  = 0;

  function automatic void add(int phase, int sel, logic v, logic [31:0] d, logic rdy,
                              logic stl, logic fl, logic ev, logic [31:0] ed, logic er,
                              int eb, int es);
    vec_t t;
    t.phase = phase; t.sel = sel; t.v = v; t.d = d; t.rdy = rdy; t.stl = stl; t.fl = fl;
    t.ev = ev; t.ed = ed; t.er = er; t.eb = eb; t.es = es;
    vq.push_back(t);
  endfunction

  task automatic check(input string tag, input string fld, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s.%s[%0d]: got %h expected %h", tag, fld, idx, act, exp);
    end
  endtask

  task automatic get_out(input int sel, output logic v, output logic [31:0] d,
                         output logic [31:0] pc, output logic r,
                         output logic [31:0] b, output logic [31:0] s);
    case (sel)
      0: begin v = s0_valid; d = s0_data; pc = s0_pc; r = s0_ready;
               b = {16'd0, s0_bub}; s = {16'd0, s0_stl}; end
      1: begin v = s1_valid; d = s1_data; pc = s1_pc; r = s1_ready;
               b = {16'd0, s1_bub}; s = {16'd0, s1_stl}; end
      default: begin v = c4_valid; d = c4_data; pc = c4_pc; r = c4_ready;
               b = {28'd0, c4_bub}; s = {28'd0, c4_stl}; end
    endcase
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; data_i = 32'd0; pc_i = 32'd0;
    ready_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
  endtask

  // Returns at a falling edge just after reset release (start of cycle 0).
  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;
  endtask

  task automatic run_phase(input int phase, input string tag);
    logic        av, ar;
    logic [31:0] ad, ap, ab, as;
    int          cyc;
    cyc = 0;
    do_reset();
    foreach (vq[i]) begin
      if (vq[i].phase == phase) begin
        valid_i = vq[i].v;   data_i  = vq[i].d;   pc_i    = vq[i].d + 32'h100;
        ready_i = vq[i].rdy; stall_i = vq[i].stl; flush_i = vq[i].fl;
        #3;
        get_out(vq[i].sel, av, ad, ap, ar, ab, as);
        check(tag, "valid", cyc, {31'd0, av}, {31'd0, vq[i].ev});
        check(tag, "data", cyc, ad, vq[i].ed);
        check(tag, "pc", cyc, ap, vq[i].ev ? vq[i].ed + 32'h100 : 32'd0);
        check(tag, "ready", cyc, {31'd0, ar}, {31'd0, vq[i].er});
        check(tag, "bubble_cnt", cyc, ab, vq[i].eb);
        check(tag, "stall_cnt", cyc, as, vq[i].es);
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
    end
    idle_inputs();
  endtask

  task automatic check_reset_values(input int sel, input string tag);
    logic        av, ar;
    logic [31:0] ad, ap, ab, as;
    get_out(sel, av, ad, ap, ar, ab, as);
    check(tag, "valid", 0, {31'd0, av}, 32'd0);
    check(tag, "data", 0, ad, 32'h13);
    check(tag, "pc", 0, ap, 32'd0);
    check(tag, "ready", 0, {31'd0, ar}, 32'd1);
    check(tag, "bubble_cnt", 0, ab, 32'd0);
    check(tag, "stall_cnt", 0, as, 32'd0);
  endtask

  initial begin
    logic        av, ar;
    logic [31:0] ad, ap, ab, as;
    rst_i = 1'b1;
    idle_inputs();

    // Phases 0/1: 8-deep stream with downstream always ready, both SKID settings.
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 10; k++) begin
        add(s, s, k < 8, (k < 8) ? 32'(k + 1) : 32'd0, 1'b1, 1'b0, 1'b0,
            (k >= 1 && k <= 8), (k >= 1 && k <= 8) ? 32'(k) : 32'h13, 1'b1,
            (k == 0) ? 0 : 1, 0);
      end
    end

    // Phase 2: SKID=1 back-pressure on cycles 3-4; upstream re-presents 5 while blocked.
    //     ph sel v     d      rdy   stl   fl    ev    ed      er    eb es
    add(2, 1, 1'b1, 32'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h13, 1'b1, 0, 0);
    add(2, 1, 1'b1, 32'd2, 1'b1, 1'b0, 1'b0, 1'b1, 32'd1,  1'b1, 1, 0);
    add(2, 1, 1'b1, 32'd3, 1'b1, 1'b0, 1'b0, 1'b1, 32'd2,  1'b1, 1, 0);
    add(2, 1, 1'b1, 32'd4, 1'b0, 1'b0, 1'b0, 1'b1, 32'd3,  1'b1, 1, 0);
    add(2, 1, 1'b1, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1, 32'd3,  1'b0, 1, 1);
    add(2, 1, 1'b1, 32'd5, 1'b1, 1'b0, 1'b0, 1'b1, 32'd3,  1'b0, 1, 2);
    add(2, 1, 1'b1, 32'd5, 1'b1, 1'b0, 1'b0, 1'b1, 32'd4,  1'b1, 1, 2);
    add(2, 1, 1'b1, 32'd6, 1'b1, 1'b0, 1'b0, 1'b1, 32'd5,  1'b1, 1, 2);
    add(2, 1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd6,  1'b1, 1, 2);
    add(2, 1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h13, 1'b1, 1, 2);

    // Phase 3: SKID=1 fills with 5,6 then flushes while 7 is offered; 7 must never show.
    add(3, 1, 1'b1, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 32'h13, 1'b1, 0, 0);
    add(3, 1, 1'b1, 32'd6, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5,  1'b1, 1, 0);
    add(3, 1, 1'b1, 32'd7, 1'b0, 1'b0, 1'b1, 1'b1, 32'd5,  1'b0, 1, 1);
    add(3, 1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h13, 1'b1, 1, 2);
    add(3, 1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h13, 1'b1, 2, 2);
    add(3, 1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h13, 1'b1, 3, 2);

    // Phase 4: SKID=0 stall for 3 cycles, flush+stall while full, flush with a payload,
    // then an accept while stalled and empty.
    add(4, 0, 1'b1, 32'd9,  1'b1, 1'b0, 1'b0, 1'b0, 32'h13, 1'b1, 0, 0);
    add(4, 0, 1'b1, 32'd10, 1'b1, 1'b1, 1'b0, 1'b1, 32'd9,  1'b0, 1, 0);
    add(4, 0, 1'b1, 32'd10, 1'b1, 1'b1, 1'b0, 1'b1, 32'd9,  1'b0, 1, 1);
    add(4, 0, 1'b1, 32'd10, 1'b1, 1'b1, 1'b0, 1'b1, 32'd9,  1'b0, 1, 2);
    add(4, 0, 1'b1, 32'd10, 1'b1, 1'b0, 1'b0, 1'b1, 32'd9,  1'b1, 1, 3);
    add(4, 0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 1'b1, 32'd10, 1'b1, 1, 3);
    add(4, 0, 1'b1, 32'd11, 1'b1, 1'b0, 1'b1, 1'b0, 32'h13, 1'b1, 1, 4);
    add(4, 0, 1'b0, 32'd0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h13, 1'b1, 2, 4);
    add(4, 0, 1'b1, 32'd12, 1'b1, 1'b1, 1'b0, 1'b0, 32'h13, 1'b1, 3, 4);
    add(4, 0, 1'b0, 32'd0,  1'b1, 1'b0, 1'b0, 1'b1, 32'd12, 1'b1, 4, 4);

    run_phase(0, "stream_s0");
    run_phase(1, "stream_s1");
    run_phase(2, "backpressure_s1");
    run_phase(3, "flush_s1");
    run_phase(4, "stall_flush_s0");

    // Asynchronous reset between edges while both stages hold payloads.
    do_reset();
    valid_i = 1'b1; data_i = 32'h21; pc_i = 32'h121;
    @(posedge clk);
    @(negedge clk);
    data_i = 32'h22; pc_i = 32'h122;
    @(posedge clk);
    #2;
    rst_i = 1'b0;
    #1;
    check_reset_values(0, "async_rst_s0");
    check_reset_values(1, "async_rst_s1");
    valid_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    valid_i = 1'b1; data_i = 32'h77; pc_i = 32'h177;
    #3;
    check("post_rst_s0", "valid", 0, {31'd0, s0_valid}, 32'd0);
    check("post_rst_s1", "valid", 0, {31'd0, s1_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    #3;
    check("post_rst_s0", "valid", 1, {31'd0, s0_valid}, 32'd1);
    check("post_rst_s0", "data", 1, s0_data, 32'h77);
    check("post_rst_s0", "pc", 1, s0_pc, 32'h177);
    check("post_rst_s1", "valid", 1, {31'd0, s1_valid}, 32'd1);
    check("post_rst_s1", "data", 1, s1_data, 32'h77);
    check("post_rst_s1", "pc", 1, s1_pc, 32'h177);
    idle_inputs();

    // Idle for 22 edges: the 4-bit bubble counter must stop at 15.
    do_reset();
    for (int k = 1; k <= 22; k++) begin
      @(posedge clk);
      #4;
      get_out(2, av, ad, ap, ar, ab, as);
      if (k == 14) check("sat_c4", "bubble_cnt", k, ab, 32'd14);
      if (k == 15) check("sat_c4", "bubble_cnt", k, ab, 32'd15);
      if (k == 20) check("sat_c4", "bubble_cnt", k, ab, 32'd15);
      if (k == 22) begin
        check("sat_c4", "bubble_cnt", k, ab, 32'd15);
        check("sat_c4", "stall_cnt", k, as, 32'd0);
        check("sat_c4", "data", k, ad, 32'h13);
        check("sat_s0", "bubble_cnt", k, {16'd0, s0_bub}, 32'd22);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
